pid_pwm_drive: RTL and testbench

PID_PWM_DRIVE -- requirements
Module: pid_pwm_drive

---
 rtl/pid_pwm_drive.sv | 101 ++++++++++
 tb/tb_pid_pwm_drive.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_drive.sv
// PID term summer with 12-bit saturation feeding a 2048-clock PWM generator.
// A new duty/direction is adopted only at the period wrap so every period is whole.
module pid_pwm_drive (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] P_term,
   input  logic [11:0] I_term,
   input  logic [12:0] D_term,
   input  logic        vld,
   output logic [10:0] duty,
   output logic        fwd,
   output logic        PWM,
   output logic        duty_upd
);

   localparam logic        [10:0] CntMax = 11'h7ff;
   localparam logic signed [14:0] SumMax = 15'sd2047;
   localparam logic signed [14:0] SumMin = -15'sd2048;
   localparam logic signed [11:0] SatMax = 12'sh7ff;
   localparam logic signed [11:0] SatMin = 12'sh800;

   logic signed [14:0] p_ext, i_ext, d_ext, sum;
   logic signed [11:0] sat;
   logic signed [11:0] drv_sat_d, drv_sat_q;
   logic        [11:0] drv_neg;
   logic               pend_fwd_d, pend_fwd_q;
   logic        [10:0] pend_mag_d, pend_mag_q;
   logic        [10:0] cnt_d, cnt_q;
   logic               wrap;
   logic        [10:0] duty_d, duty_q;
   logic               fwd_d, fwd_q;
   logic               pwm_d, pwm_q;
   logic               duty_upd_d, duty_upd_q;

   // Stage 1: 15 bits holds the widest possible sum, so nothing wraps before saturation.
   always_comb begin
      p_ext = {{1{P_term[13]}}, P_term};
      i_ext = {{3{I_term[11]}}, I_term};
      d_ext = {{2{D_term[12]}}, D_term};
      sum   = p_ext + i_ext + d_ext;
      if (sum > SumMax) begin
         sat = SatMax;
      end else if (sum < SumMin) begin
         sat = SatMin;
      end else begin
         sat = sum[11:0];
      end
      drv_sat_d = vld ? sat : drv_sat_q;
   end

   // Stage 2: sign/magnitude split; -2048 has no 11-bit magnitude and clips to full scale.
   always_comb begin
      pend_fwd_d = ~drv_sat_q[11];
      drv_neg    = 12'd0 - drv_sat_q;
      if (pend_fwd_d) begin
         pend_mag_d = drv_sat_q[10:0];
      end else if (drv_sat_q == SatMin) begin
         pend_mag_d = 11'h7ff;
      end else begin
         pend_mag_d = drv_neg[10:0];
      end
   end

   // PWM output is computed from next-state values so the flop matches the new cycle.
   always_comb begin
      cnt_d      = cnt_q + 11'd1;
      wrap       = (cnt_q == CntMax);
      duty_d     = wrap ? pend_mag_q : duty_q;
      fwd_d      = wrap ? pend_fwd_q : fwd_q;
      pwm_d      = (cnt_d < duty_d);
      duty_upd_d = wrap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drv_sat_q  <= '0;
         pend_fwd_q <= 1'b1;
         pend_mag_q <= '0;
         cnt_q      <= '0;
         duty_q     <= '0;
         fwd_q      <= 1'b1;
         pwm_q      <= 1'b0;
         duty_upd_q <= 1'b0;
      end else begin
         drv_sat_q  <= drv_sat_d;
         pend_fwd_q <= pend_fwd_d;
         pend_mag_q <= pend_mag_d;
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         fwd_q      <= fwd_d;
         pwm_q      <= pwm_d;
         duty_upd_q <= duty_upd_d;
      end
   end

   assign duty     = duty_q;
   assign fwd      = fwd_q;
   assign PWM      = pwm_q;
   assign duty_upd = duty_upd_q;

endmodule

// File: tb/tb_pid_pwm_drive.sv
// Directed bench for pid_pwm_drive; a local counter model tracks the PWM period phase.
module tb_pid_pwm_drive;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [13:0] P_term = '0;
   logic [11:0] I_term = '0;
   logic [12:0] D_term = '0;
   logic        vld = 1'b0;
   logic [10:0] duty;
   logic        fwd;
   logic        PWM;
   logic        duty_upd;

   int n_checks = 0;
   int n_errors = 0;
   int highs, upds;
   logic [10:0] m_cnt;

   pid_pwm_drive dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .P_term   (P_term),
      .I_term   (I_term),
      .D_term   (D_term),
      .vld      (vld),
      .duty     (duty),
      .fwd      (fwd),
      .PWM      (PWM),
      .duty_upd (duty_upd)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_cnt <= '0;
      else        m_cnt <= m_cnt + 11'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cnt(input int k);
      int budget = 5000;
      while (m_cnt != k[10:0] && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (m_cnt != k[10:0]) check("wait_cnt", {21'd0, m_cnt}, k);
   endtask

   task automatic measure(input int cycles, output int h, output int u);
      h = 0;
      u = 0;
      for (int n = 0; n < cycles; n++) begin
         if (PWM === 1'b1) h++;
         if (duty_upd === 1'b1) u++;
         @(negedge clk);
      end
   endtask

   task automatic pulse(input logic [13:0] p, input logic [11:0] i, input logic [12:0] d);
      P_term = p;
      I_term = i;
      D_term = d;
      vld    = 1'b1;
      @(negedge clk);
      vld    = 1'b0;
   endtask

   initial begin
      // Reset state, no clock edge needed
      #12;
      check("rst_duty", duty, 0);
      check("rst_fwd", fwd, 1);
      check("rst_pwm", PWM, 0);
      check("rst_upd", duty_upd, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("upd_cnt1", duty_upd, 0);
      wait_cnt(2047);
      check("upd_cnt2047", duty_upd, 0);
      @(negedge clk);
      check("first_wrap_upd", duty_upd, 1);
      check("first_wrap_duty", duty, 0);

      // Positive in range: 1536 + 256
      wait_cnt(10);
      pulse(14'h0600, 12'h100, 13'h0);
      wait_cnt(2047);
      check("pos_pre_wrap_duty", duty, 0);
      @(negedge clk);
      check("pos_duty", duty, 1792);
      check("pos_fwd", fwd, 1);
      measure(2048, highs, upds);
      check("pos_highs", highs, 1792);
      check("pos_upds", upds, 1);

      // Positive saturation: 3069 + 2047 + 4095
      wait_cnt(10);
      pulse(14'h0BFD, 12'h7FF, 13'h0FFF);
      wait_cnt(0);
      check("psat_duty", duty, 2047);
      check("psat_fwd", fwd, 1);
      measure(2048, highs, upds);
      check("psat_highs", highs, 2047);
      check("psat_upds", upds, 1);

      // Negative: -1536
      wait_cnt(10);
      pulse(14'h3A00, 12'h0, 13'h0);
      wait_cnt(0);
      check("neg_duty", duty, 1536);
      check("neg_fwd", fwd, 0);
      measure(2048, highs, upds);
      check("neg_highs", highs, 1536);

      // Negative saturation: -3072 - 2048 - 4096
      wait_cnt(10);
      pulse(14'h3400, 12'h800, 13'h1000);
      wait_cnt(0);
      check("nsat_duty", duty, 2047);
      check("nsat_fwd", fwd, 0);

      // Mid-period update holds until the wrap
      wait_cnt(100);
      pulse(14'd300, 12'h0, 13'h0);
      wait_cnt(2047);
      check("mid_hold_duty", duty, 2047);
      check("mid_hold_fwd", fwd, 0);
      @(negedge clk);
      check("mid_duty", duty, 300);
      check("mid_fwd", fwd, 1);
      check("mid_upd", duty_upd, 1);

      // vld at cnt=2046 is too late for this wrap
      wait_cnt(2046);
      pulse(14'd500, 12'h0, 13'h0);
      @(negedge clk);
      check("late_defer_duty", duty, 300);
      wait_cnt(2047);
      @(negedge clk);
      check("late_adopt_duty", duty, 500);

      // vld at cnt=2045 still makes this wrap
      wait_cnt(2045);
      pulse(14'd600, 12'h0, 13'h0);
      wait_cnt(0);
      check("edge_adopt_duty", duty, 600);

      // Back-to-back vld: last one wins, drv_sat holds once vld drops
      wait_cnt(200);
      P_term = 14'd700;
      vld    = 1'b1;
      @(negedge clk);
      P_term = 14'd800;
      @(negedge clk);
      vld    = 1'b0;
      P_term = 14'h1000;
      I_term = 12'h800;
      wait_cnt(0);
      check("b2b_duty", duty, 800);
      check("b2b_fwd", fwd, 1);
      I_term = 12'h0;

      // Zero over three periods
      wait_cnt(10);
      pulse(14'h0, 12'h0, 13'h0);
      wait_cnt(0);
      check("zero_duty", duty, 0);
      check("zero_fwd", fwd, 1);
      measure(3 * 2048, highs, upds);
      check("zero_highs", highs, 0);
      check("zero_upds", upds, 3);

      // Reset mid-period with duty=1000
      wait_cnt(10);
      pulse(14'd1000, 12'h0, 13'h0);
      wait_cnt(0);
      check("rst_pre_duty", duty, 1000);
      wait_cnt(500);
      check("rst_pre_pwm", PWM, 1);
      rst_n = 1'b0;
      #1;
      check("arst_pwm", PWM, 0);
      check("arst_duty", duty, 0);
      check("arst_fwd", fwd, 1);
      check("arst_upd", duty_upd, 0);
      @(negedge clk);
      rst_n = 1'b1;
      measure(4096, highs, upds);
      check("post_rst_highs", highs, 0);
      check("post_rst_upds", upds, 1);
      check("post_rst_duty", duty, 0);
      check("post_rst_fwd", fwd, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
